vr16_reg_arbiter: RTL and testbench

Arbitrates the VR16 general-purpose register file between the core writeback path (control unit + ALU) and a debug host port. Sits between the control unit/ALU and gp_registers; owns the register-file write port and read port one, sequences each write as a request → write_enable pulse → write_done handshake, and stalls the core while the debug host holds the port. Core has priority, bounded by a starvation counter; a timeout keeps a lost write_done from hanging either requester.

---
 rtl/vr16_reg_arbiter_pkg.sv | 30 +++
 rtl/vr16_sat_counter.sv | 34 +++
 rtl/vr16_reg_arbiter.sv | 155 +++++++++++++++
 tb/tb_vr16_reg_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vr16_reg_arbiter_pkg.sv
// Shared VR16 definitions: datapath widths, register names and arbiter state encodings.
package vr16_reg_arbiter_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 2;

    typedef enum logic [REG_ADDR_W-1:0] {
        REG_A = 2'd0,
        REG_B = 2'd1,
        REG_C = 2'd2,
        REG_D = 2'd3
    } vr16_reg_e;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_CORE_WR = 3'd1;
    localparam logic [STATE_W-1:0] ST_DBG_WR  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DBG_RD0 = 3'd3;
    localparam logic [STATE_W-1:0] ST_DBG_RD1 = 3'd4;

    function automatic logic is_wr_state(input logic [STATE_W-1:0] s);
        return (s == ST_CORE_WR) || (s == ST_DBG_WR);
    endfunction

    function automatic logic is_dbg_state(input logic [STATE_W-1:0] s);
        return (s == ST_DBG_WR) || (s == ST_DBG_RD0) || (s == ST_DBG_RD1);
    endfunction

endpackage

// File: rtl/vr16_sat_counter.sv
// Saturating up-counter with synchronous clear; sat_o flags that the limit has been reached.
module vr16_sat_counter #(
    parameter int          W     = 3,
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic sat_o
);

    logic [W-1:0] count_q, count_d;

    assign sat_o = (count_q == W'(LIMIT));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !sat_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vr16_reg_arbiter.sv
// Arbitrates the VR16 register-file write port and read port one between core writeback
// and a debug host; core has priority until the debug host has waited STARVE_LIMIT cycles.
module vr16_reg_arbiter
    import vr16_reg_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_wr_req,
    input  logic [REG_ADDR_W-1:0] core_wr_addr,
    input  logic [WORD_W-1:0]     core_wr_data,
    input  logic [REG_ADDR_W-1:0] core_rd_addr_one,
    input  logic [REG_ADDR_W-1:0] core_rd_addr_two,
    output logic                  core_wr_done,
    output logic                  core_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [WORD_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_done,
    output logic [WORD_W-1:0]     dbg_rdata,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_store_at,
    output logic [WORD_W-1:0]     rf_write_data,
    output logic [REG_ADDR_W-1:0] rf_read_one,
    output logic [REG_ADDR_W-1:0] rf_read_two,
    input  logic [WORD_W-1:0]     rf_operand_one,
    input  logic                  rf_write_done,
    output logic                  arb_error
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int TMO_W    = $clog2(TIMEOUT);

    logic [STATE_W-1:0]    state_q, state_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] store_q, store_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;
    logic                  cdone_q, cdone_d;
    logic                  ddone_q, ddone_d;
    logic                  err_q, err_d;
    logic                  grant_dbg;
    logic                  starve_sat;
    logic                  tmo_sat;
    logic                  dbg_owns;

    assign dbg_owns = is_dbg_state(state_q);

    vr16_sat_counter #(.W(STARVE_W), .LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr_i (!dbg_req || dbg_owns || grant_dbg),
        .inc_i (1'b1),
        .sat_o (starve_sat)
    );

    // Saturates on the TIMEOUT-th cycle in a write state, the last cycle rf_write_done is accepted.
    vr16_sat_counter #(.W(TMO_W), .LIMIT(TIMEOUT - 1)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr_i (!is_wr_state(state_q)),
        .inc_i (1'b1),
        .sat_o (tmo_sat)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        cdone_d   = 1'b0;
        ddone_d   = 1'b0;
        err_d     = 1'b0;
        store_d   = store_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        grant_dbg = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A done pulse means the requester may still show its old request level.
                if (!(cdone_q || ddone_q)) begin
                    if (core_wr_req && !(dbg_req && starve_sat)) begin
                        state_d = ST_CORE_WR;
                        we_d    = 1'b1;
                        store_d = core_wr_addr;
                        wdata_d = core_wr_data;
                    end else if (dbg_req) begin
                        grant_dbg = 1'b1;
                        if (dbg_we) begin
                            state_d = ST_DBG_WR;
                            we_d    = 1'b1;
                            store_d = dbg_addr;
                            wdata_d = dbg_wdata;
                        end else begin
                            state_d = ST_DBG_RD0;
                        end
                    end
                end
            end
            ST_CORE_WR, ST_DBG_WR: begin
                if (rf_write_done || tmo_sat) begin
                    state_d = ST_IDLE;
                    cdone_d = (state_q == ST_CORE_WR);
                    ddone_d = (state_q == ST_DBG_WR);
                    err_d   = !rf_write_done;
                end
            end
            ST_DBG_RD0: state_d = ST_DBG_RD1;
            ST_DBG_RD1: begin
                rdata_d = rf_operand_one;
                ddone_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            store_q <= REG_A;
            wdata_q <= '0;
            rdata_q <= '0;
            cdone_q <= 1'b0;
            ddone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            store_q <= store_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cdone_q <= cdone_d;
            ddone_q <= ddone_d;
            err_q   <= err_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_store_at     = store_q;
    assign rf_write_data   = wdata_q;
    assign core_wr_done    = cdone_q;
    assign dbg_done        = ddone_q;
    assign dbg_rdata       = rdata_q;
    assign arb_error       = err_q;
    assign dbg_gnt         = dbg_owns;
    assign core_stall      = dbg_owns;
    assign rf_read_one     = (state_q == ST_DBG_RD0 || state_q == ST_DBG_RD1) ? dbg_addr
                                                                               : core_rd_addr_one;
    assign rf_read_two     = core_rd_addr_two;

endmodule

// File: tb/tb_vr16_reg_arbiter.sv
// Directed and randomized checks of vr16_reg_arbiter against a transaction-level owner model.
module tb_vr16_reg_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    localparam int O_NONE = 0;
    localparam int O_CORE = 1;
    localparam int O_DWR  = 2;
    localparam int O_DRD  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_wr_req;
    logic [1:0]  core_wr_addr;
    logic [15:0] core_wr_data;
    logic [1:0]  core_rd_addr_one, core_rd_addr_two;
    logic        core_wr_done, core_stall;
    logic        dbg_req, dbg_we;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_gnt, dbg_done;
    logic [15:0] dbg_rdata;
    logic        rf_write_enable;
    logic [1:0]  rf_store_at;
    logic [15:0] rf_write_data;
    logic [1:0]  rf_read_one, rf_read_two;
    logic [15:0] rf_operand_one;
    logic        rf_write_done;
    logic        arb_error;

    vr16_reg_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .core_wr_req(core_wr_req), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_rd_addr_one(core_rd_addr_one), .core_rd_addr_two(core_rd_addr_two),
        .core_wr_done(core_wr_done), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
        .rf_write_enable(rf_write_enable), .rf_store_at(rf_store_at), .rf_write_data(rf_write_data),
        .rf_read_one(rf_read_one), .rf_read_two(rf_read_two),
        .rf_operand_one(rf_operand_one), .rf_write_done(rf_write_done), .arb_error(arb_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: who owns the port, for how many cycles, and the visible registered outputs.
    int          m_owner, m_age, m_starve;
    logic [1:0]  m_addr;
    logic [15:0] m_wdata, m_rdata;
    logic        m_we, m_cdone, m_ddone, m_err;

    // Register-file responder: acknowledges ack_lat cycles after each strobe.
    int ack_en = 0, ack_lat = 1, ack_cnt = -1;
    bit spurious = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = O_NONE; m_age = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        m_we = 1'b0; m_cdone = 1'b0; m_ddone = 1'b0; m_err = 1'b0;
        ack_cnt = -1;
    endtask

    task automatic check_all();
        chk("rf_write_enable", 32'(rf_write_enable), 32'(m_we));
        chk("core_wr_done",    32'(core_wr_done),    32'(m_cdone));
        chk("dbg_done",        32'(dbg_done),        32'(m_ddone));
        chk("arb_error",       32'(arb_error),       32'(m_err));
        chk("dbg_gnt",         32'(dbg_gnt),         32'(m_owner == O_DWR || m_owner == O_DRD));
        chk("core_stall",      32'(core_stall),      32'(m_owner == O_DWR || m_owner == O_DRD));
        chk("rf_store_at",     32'(rf_store_at),     32'(m_addr));
        chk("rf_write_data",   32'(rf_write_data),   32'(m_wdata));
        chk("dbg_rdata",       32'(dbg_rdata),       32'(m_rdata));
        chk("rf_read_one",     32'(rf_read_one),     32'((m_owner == O_DRD) ? dbg_addr : core_rd_addr_one));
        chk("rf_read_two",     32'(rf_read_two),     32'(core_rd_addr_two));
    endtask

    // Predict from inputs of the current cycle, clock once, then compare everything.
    task automatic tick();
        int          n_owner, n_age, n_starve;
        logic [1:0]  n_addr;
        logic [15:0] n_wdata, n_rdata;
        logic        n_we, n_cdone, n_ddone, n_err;
        bit          dbg_served;
        n_owner = m_owner; n_age = m_age + 1; n_starve = m_starve;
        n_addr = m_addr; n_wdata = m_wdata; n_rdata = m_rdata;
        n_we = 1'b0; n_cdone = 1'b0; n_ddone = 1'b0; n_err = 1'b0;
        dbg_served = (m_owner == O_DWR || m_owner == O_DRD);
        if (m_owner == O_NONE) begin
            n_age = 1;
            if (!m_cdone && !m_ddone) begin
                if (core_wr_req && (!dbg_req || m_starve < STARVE_LIMIT)) begin
                    n_owner = O_CORE; n_we = 1'b1; n_addr = core_wr_addr; n_wdata = core_wr_data;
                end else if (dbg_req) begin
                    dbg_served = 1'b1;
                    if (dbg_we) begin
                        n_owner = O_DWR; n_we = 1'b1; n_addr = dbg_addr; n_wdata = dbg_wdata;
                    end else begin
                        n_owner = O_DRD;
                    end
                end
            end
        end else if (m_owner == O_CORE || m_owner == O_DWR) begin
            if (rf_write_done || m_age == TIMEOUT) begin
                n_owner = O_NONE;
                n_cdone = (m_owner == O_CORE);
                n_ddone = (m_owner == O_DWR);
                n_err   = !rf_write_done;
            end
        end else if (m_age == 2) begin
            n_rdata = rf_operand_one; n_ddone = 1'b1; n_owner = O_NONE;
        end
        if (!dbg_req || dbg_served) n_starve = 0;
        else n_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;

        @(posedge clk); #1;
        m_owner = n_owner; m_age = n_age; m_starve = n_starve;
        m_addr = n_addr; m_wdata = n_wdata; m_rdata = n_rdata;
        m_we = n_we; m_cdone = n_cdone; m_ddone = n_ddone; m_err = n_err;
        check_all();

        rf_write_done = 1'b0;
        if (ack_en != 0 && m_we) ack_cnt = ack_lat;
        if (ack_cnt == 0) rf_write_done = 1'b1;
        else if (spurious && ack_cnt < 0 && m_owner != O_CORE && m_owner != O_DWR &&
                 $urandom_range(15) == 0) rf_write_done = 1'b1;
        if (ack_cnt >= 0) ack_cnt--;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_gnt, core_wins, err_early, done_seen;
        bit cpend, dpend;

        reset = 1'b1;
        core_wr_req = 0; core_wr_addr = 0; core_wr_data = 0;
        core_rd_addr_one = 0; core_rd_addr_two = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        rf_operand_one = 0; rf_write_done = 0;
        #1;
        model_reset();
        chk("reset_we", 32'(rf_write_enable), 32'd0);
        chk("reset_rdata", 32'(dbg_rdata), 32'd0);
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // Core-only write, acknowledged one cycle after the strobe.
        ack_en = 1; ack_lat = 1;
        core_wr_req = 1; core_wr_addr = 2; core_wr_data = 16'h1234;
        tick();
        chk("core_c1_we", 32'(rf_write_enable), 32'd1);
        chk("core_c1_addr", 32'(rf_store_at), 32'd2);
        chk("core_c1_data", 32'(rf_write_data), 32'h1234);
        chk("core_c1_stall", 32'(core_stall), 32'd0);
        tick();
        chk("core_c2_done", 32'(core_wr_done), 32'd0);
        tick();
        chk("core_c3_done", 32'(core_wr_done), 32'd1);
        chk("core_c3_stall", 32'(core_stall), 32'd0);
        core_wr_req = 0;
        tick();
        chk("core_c4_done", 32'(core_wr_done), 32'd0);

        // Debug read.
        dbg_req = 1; dbg_we = 0; dbg_addr = 3; rf_operand_one = 16'hBEEF;
        tick();
        chk("drd_c1_rd1", 32'(rf_read_one), 32'd3);
        chk("drd_c1_stall", 32'(core_stall), 32'd1);
        tick();
        chk("drd_c2_rd1", 32'(rf_read_one), 32'd3);
        chk("drd_c2_stall", 32'(core_stall), 32'd1);
        tick();
        chk("drd_c3_done", 32'(dbg_done), 32'd1);
        chk("drd_c3_rdata", 32'(dbg_rdata), 32'hBEEF);
        chk("drd_c3_stall", 32'(core_stall), 32'd0);
        dbg_req = 0;
        tick(); tick();

        // Contention: debug waits through one core write, then wins the next decision.
        core_wr_req = 1; core_wr_addr = 0; core_wr_data = 16'h1111;
        dbg_req = 1; dbg_we = 1; dbg_addr = 1; dbg_wdata = 16'h2222;
        first_gnt = -1; core_wins = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (dbg_gnt && first_gnt < 0) first_gnt = c;
            if (core_wr_done && first_gnt < 0) core_wins++;
            if (dbg_done) dbg_req = 0;
        end
        chk("contend_first_dbg_gnt", 32'(first_gnt), 32'd5);
        chk("contend_core_wins", 32'(core_wins), 32'd1);
        core_wr_req = 0; dbg_req = 0;
        for (int c = 0; c < 6; c++) tick();

        // Timeout: no acknowledge at all.
        ack_en = 0;
        core_wr_req = 1; core_wr_addr = 1; core_wr_data = 16'hABCD;
        tick();
        chk("tmo_c1_we", 32'(rf_write_enable), 32'd1);
        err_early = 0;
        for (int c = 2; c <= TIMEOUT; c++) begin
            tick();
            if (arb_error || core_wr_done) err_early++;
        end
        chk("tmo_no_early_abort", 32'(err_early), 32'd0);
        tick();
        chk("tmo_err", 32'(arb_error), 32'd1);
        chk("tmo_done", 32'(core_wr_done), 32'd1);
        core_wr_req = 0;
        tick();
        chk("tmo_err_clear", 32'(arb_error), 32'd0);
        tick();

        // Reset in the cycle after a debug write strobe.
        dbg_req = 1; dbg_we = 1; dbg_addr = 2; dbg_wdata = 16'h5A5A;
        tick();
        chk("rst_c1_we", 32'(rf_write_enable), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_addr", 32'(rf_store_at), 32'd0);
        chk("rst_data", 32'(rf_write_data), 32'd0);
        check_all();
        dbg_req = 0;
        @(posedge clk); #1;
        check_all();
        reset = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (dbg_done) done_seen++;
        end
        chk("rst_no_dbg_done", 32'(done_seen), 32'd0);
        ack_en = 1; ack_lat = 1;
        core_wr_req = 1; core_wr_addr = 3; core_wr_data = 16'h7777;
        tick(); tick(); tick();
        chk("post_rst_done", 32'(core_wr_done), 32'd1);
        chk("post_rst_addr", 32'(rf_store_at), 32'd3);
        chk("post_rst_data", 32'(rf_write_data), 32'h7777);
        core_wr_req = 0;
        tick(); tick();

        // Randomized traffic from both requesters with variable (sometimes missing) acknowledges.
        spurious = 1'b1;
        cpend = 1'b0; dpend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            core_rd_addr_one = 2'($urandom);
            core_rd_addr_two = 2'($urandom);
            rf_operand_one   = 16'($urandom);
            ack_lat          = $urandom_range(10);
            if (core_wr_done) cpend = 1'b1;
            else if (cpend || (!core_wr_req && $urandom_range(2) == 0)) begin
                core_wr_req  = cpend ? 1'($urandom) : 1'b1;
                cpend        = 1'b0;
                core_wr_addr = 2'($urandom);
                core_wr_data = 16'($urandom);
            end
            if (dbg_done) dpend = 1'b1;
            else if (dpend || (!dbg_req && $urandom_range(3) == 0)) begin
                dbg_req   = dpend ? 1'($urandom) : 1'b1;
                dpend     = 1'b0;
                dbg_we    = 1'($urandom);
                dbg_addr  = 2'($urandom);
                dbg_wdata = 16'($urandom);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
